// File: rtl/paralelo_serial_param.sv
// Single-clock parallel-to-serial converter with valid/ready intake and idle-word fill.
// Optional PARITY_BIT_EN appends an even-parity bit after each word's LSB.
`timescale 1ns/1ps

module paralelo_serial_param #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD  = WIDTH'(8'hBC),
  parameter int unsigned      SYNC_WORDS = 4
) (
  input  logic             clk_32f,
  input  logic             reset_L,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready_out,
  output logic             data_out,
  output logic             active_out
);

`ifdef PARITY_BIT_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam int unsigned CntW  = $clog2(FRAME);
  localparam int unsigned SyncW = (SYNC_WORDS > 0) ? $clog2(SYNC_WORDS + 1) : 1;

  typedef enum logic [0:0] {StSync, StActive} state_e;

  localparam state_e ResetState = (SYNC_WORDS == 0) ? StActive : StSync;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [FRAME-1:0]   shreg_q, shreg_d;
  logic [SyncW-1:0]   sync_q, sync_d;
  logic [WIDTH-1:0]   word;
  logic               load;

  assign load = (cnt_q == CntW'(FRAME - 1));

  always_comb begin
    state_d = state_q;
    sync_d  = sync_q;
    cnt_d   = cnt_q + 1'b1;
    shreg_d = {shreg_q[FRAME-2:0], 1'b0};
    word    = IDLE_WORD;
    if (load) begin
      cnt_d = '0;
      unique case (state_q)
        StSync: begin
          sync_d = sync_q + 1'b1;
          // The load that fetches the last sync idle word also opens the link.
          if (sync_q == SyncW'(SYNC_WORDS - 1)) state_d = StActive;
        end
        StActive: begin
          if (valid_in) word = data_in;
        end
        default: ;
      endcase
`ifdef PARITY_BIT_EN
      shreg_d = {word, ^word};
`else
      shreg_d = word;
`endif
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ResetState;
      cnt_q   <= CntW'(FRAME - 1);
      shreg_q <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      sync_q  <= sync_d;
    end
  end

  assign data_out   = shreg_q[FRAME-1];
  assign active_out = (state_q == StActive);
  assign ready_out  = (state_q == StActive) && load;

endmodule
